// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register master: FSM state encoding and
// command-word field positions (expressed as offsets below the word MSB so
// they hold for any REG_W).
package spi_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   // RW flag sits at bit REG_W - CMD_RW_OFS
   localparam int CMD_RW_OFS    = 1;
   // width field occupies [REG_W-CMD_WIDTH_OFS+1 : REG_W-CMD_WIDTH_OFS]
   localparam int CMD_WIDTH_OFS = 3;
   localparam int CMD_WIDTH_W   = 2;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: down-counter that raises a one-cycle tick every
// HALF_PERIOD cycles. Held at its top value while clr is high so that the
// first tick after release lands exactly HALF_PERIOD cycles later.
module spi_half_period_timer #(
   parameter int HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rstb,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W   = $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] cnt_r;

   // reload on clear or expiry, otherwise count down
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_r <= CNT_TOP;
      end else if (clr || (cnt_r == CNT_ZERO)) begin
         cnt_r <= CNT_TOP;
      end else begin
         cnt_r <= cnt_r - CNT_ONE;
      end
   end

   assign tick = (cnt_r == CNT_ZERO) && !clr;

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master. Serialises {cmd, data} MSB first per request,
// captures the read word from MISO in the data phase of reads.
// Build option: define SPI_REG_MASTER_MISO_SYNC_EN to pass MISO through a
// 2-flop synchroniser; sampling then occurs 2 cycles after each rising edge.
// Pin timing is the same in both builds.
module spi_reg_master
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int REG_W       = 32,
   parameter int HALF_PERIOD = 4
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [1:0]        req_width,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [REG_W-1:0]  req_wdata,
   output logic              resp_valid,
   output logic [REG_W-1:0]  resp_rdata,
   output logic              spi_clk,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int               FRAME_W  = 2 * REG_W;
   localparam int               BIT_W    = $clog2(FRAME_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
   localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(REG_W);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam int               RW_POS   = REG_W - CMD_RW_OFS;
   localparam int               WID_LO   = REG_W - CMD_WIDTH_OFS;

   spi_state_e         state_r;
   logic               ready_r;
   logic               resp_valid_r;
   logic [REG_W-1:0]   resp_rdata_r;
   logic               spi_clk_r;
   logic               cs_n_r;
   logic               mosi_r;
   logic [FRAME_W-2:0] frame_r;
   logic [BIT_W-1:0]   bit_cnt_r;
   logic               rw_r;
   logic [REG_W-1:0]   rd_sh_r;

   logic [REG_W-1:0]   cmd_s;
   logic [FRAME_W-1:0] frame_s;
   logic               tick_s;
   logic               samp_s;
   logic               cap_en_s;
   logic               cap_bit_s;

   spi_half_period_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_timer (
      .clk  (clk),
      .rstb (rstb),
      .clr  (state_r == ST_IDLE),
      .tick (tick_s)
   );

   // assemble command word and full outgoing frame from the live request
   always_comb begin
      cmd_s                          = {REG_W{1'b0}};
      cmd_s[RW_POS]                  = req_rw;
      cmd_s[WID_LO +: CMD_WIDTH_W]   = req_width;
      cmd_s[ADDR_W-1:0]              = req_addr;
      frame_s = {cmd_s, (req_rw ? req_wdata : {REG_W{1'b0}})};
   end

   // MISO sample point: spi_clk being driven high during a read data bit
   assign samp_s = (state_r == ST_SHIFT) && tick_s && !spi_clk_r && !rw_r
                   && (bit_cnt_r >= BIT_DATA);

`ifdef SPI_REG_MASTER_MISO_SYNC_EN
   logic miso_s1_r;
   logic miso_s2_r;
   logic samp_d1_r;
   logic samp_d2_r;

   // two-flop MISO synchroniser with a matching two-cycle sample strobe delay
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         miso_s1_r <= 1'b0;
         miso_s2_r <= 1'b0;
         samp_d1_r <= 1'b0;
         samp_d2_r <= 1'b0;
      end else begin
         miso_s1_r <= spi_miso;
         miso_s2_r <= miso_s1_r;
         samp_d1_r <= samp_s;
         samp_d2_r <= samp_d1_r;
      end
   end

   assign cap_en_s  = samp_d2_r;
   assign cap_bit_s = miso_s2_r;
`else
   assign cap_en_s  = samp_s;
   assign cap_bit_s = spi_miso;
`endif

   // read-data shift register, MSB first
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rd_sh_r <= {REG_W{1'b0}};
      end else if (cap_en_s) begin
         rd_sh_r <= {rd_sh_r[REG_W-2:0], cap_bit_s};
      end else begin
         rd_sh_r <= rd_sh_r;
      end
   end

   // frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r      <= ST_IDLE;
         ready_r      <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= {REG_W{1'b0}};
         spi_clk_r    <= 1'b0;
         cs_n_r       <= 1'b1;
         mosi_r       <= 1'b0;
         frame_r      <= {(FRAME_W-1){1'b0}};
         bit_cnt_r    <= {BIT_W{1'b0}};
         rw_r         <= 1'b0;
      end else begin
         resp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid && ready_r) begin
                  state_r   <= ST_SETUP;
                  ready_r   <= 1'b0;
                  cs_n_r    <= 1'b0;
                  mosi_r    <= frame_s[FRAME_W-1];
                  frame_r   <= frame_s[FRAME_W-2:0];
                  bit_cnt_r <= {BIT_W{1'b0}};
                  rw_r      <= req_rw;
               end
            end
            ST_SETUP: begin
               if (tick_s) begin
                  state_r   <= ST_SHIFT;
                  spi_clk_r <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (tick_s) begin
                  if (spi_clk_r) begin
                     spi_clk_r <= 1'b0;
                     if (bit_cnt_r == BIT_LAST) begin
                        state_r <= ST_HOLD;
                        mosi_r  <= 1'b0;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        mosi_r    <= frame_r[FRAME_W-2];
                        frame_r   <= {frame_r[FRAME_W-3:0], 1'b0};
                     end
                  end else begin
                     spi_clk_r <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (tick_s) begin
                  state_r <= ST_GAP;
                  cs_n_r  <= 1'b1;
               end
            end
            ST_GAP: begin
               if (tick_s) begin
                  state_r      <= ST_IDLE;
                  ready_r      <= 1'b1;
                  resp_valid_r <= 1'b1;
                  if (!rw_r) begin
                     resp_rdata_r <= rd_sh_r;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               ready_r   <= 1'b1;
               spi_clk_r <= 1'b0;
               cs_n_r    <= 1'b1;
               mosi_r    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign spi_clk    = spi_clk_r;
   assign spi_cs_n   = cs_n_r;
   assign spi_mosi   = mosi_r;

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: table vectors, random transactions
// against a frame-level model, plus back-to-back, busy-pulse and mid-frame
// reset sequences. A behavioural SPI target drives MISO and scrambles it
// while spi_clk is high so only the sample-point level can be captured.
module tb_spi_reg_master;

   localparam int ADDR_W = 6;
   localparam int REG_W  = 32;
   localparam int HP     = 4;
   localparam int RESP_LAT = (4 * REG_W + 2) * HP + 1;   // t+521

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_rw = 1'b0;
   logic [1:0]  req_width = 2'b00;
   logic [5:0]  req_addr = 6'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        spi_miso = 1'b0;
   logic        req_ready, resp_valid, spi_clk, spi_cs_n, spi_mosi;
   logic [31:0] resp_rdata;

   spi_reg_master #(.ADDR_W(ADDR_W), .REG_W(REG_W), .HALF_PERIOD(HP)) dut (
      .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .req_width(req_width), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // target / monitor state
   logic [31:0] tgt_word = 32'd0;
   logic        prev_clk = 1'b0, prev_cs = 1'b1;
   int          cs_fall_cyc = 0, rise_k = 0, fall_j = 0, terr = 0;
   int          frames = 0, resp_cnt = 0;
   logic [63:0] bits = 64'd0;
   logic [63:0] snap_bits = 64'd0;
   int          snap_rise = 0, snap_terr = 0, snap_resp_cyc = 0;
   logic        snap_ready = 1'b0, snap_cs = 1'b0;
   logic [31:0] model_rdata = 32'd0;

   typedef struct {
      logic        rw;
      logic [1:0]  w;
      logic [5:0]  a;
      logic [31:0] wd;
      logic [31:0] tw;
      logic [31:0] exp_cmd;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t tbl [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // SPI target model and frame monitor, evaluated on the falling clk edge
   initial begin
      forever begin
         @(negedge clk);
         if (rstb) begin
            if (prev_cs && !spi_cs_n) begin
               frames++; cs_fall_cyc = cyc; rise_k = 0; fall_j = 0; bits = 64'd0; terr = 0;
            end
            if (!prev_cs && spi_cs_n && (cyc - cs_fall_cyc != (4 * REG_W + 1) * HP)) terr++;
            if (!prev_clk && spi_clk) begin
               if (cyc - cs_fall_cyc != (2 * rise_k + 1) * HP) terr++;
               if (spi_cs_n) terr++;
               bits = {bits[62:0], spi_mosi};
               rise_k++;
               spi_miso = 1'($urandom);
            end
            if (prev_clk && !spi_clk) begin
               if (cyc - cs_fall_cyc != 2 * (fall_j + 1) * HP) terr++;
               if (fall_j >= REG_W - 1 && fall_j < 2 * REG_W - 1)
                  spi_miso = tgt_word[2 * REG_W - 2 - fall_j];
               fall_j++;
            end
            if (spi_cs_n && spi_mosi) terr++;
            if (resp_valid) begin
               resp_cnt++;
               snap_bits = bits; snap_rise = rise_k; snap_terr = terr;
               snap_resp_cyc = cyc; snap_ready = req_ready; snap_cs = spi_cs_n;
            end
         end
         prev_clk = spi_clk;
         prev_cs  = spi_cs_n;
      end
   end

   task automatic drive(input logic rw, input logic [1:0] w, input logic [5:0] a, input logic [31:0] wd);
      req_rw = rw; req_width = w; req_addr = a; req_wdata = wd; req_valid = 1'b1;
   endtask

   // wait for ready, let the handshake edge pass; returns cycle index after it
   task automatic accept(output int acc);
      int n;
      n = 0;
      while (!req_ready && n < 2000) begin @(negedge clk); #1; n++; end
      chk("accept_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
      acc = cyc;
   endtask

   task automatic wait_resp(input int r0);
      int n;
      n = 0;
      while (resp_cnt == r0 && n < 2000) begin @(negedge clk); #1; n++; end
      chk("resp_seen", 64'(resp_cnt), 64'(r0 + 1));
   endtask

   task automatic check_frame(input string tag, input logic rw, input logic [31:0] wd,
                              input logic [31:0] exp_cmd, input logic [31:0] exp_rdata, input int acc);
      chk({tag, "_frame_bits"}, snap_bits, {exp_cmd, (rw ? wd : 32'd0)});
      chk({tag, "_rise_count"}, 64'(snap_rise), 64'(2 * REG_W));
      chk({tag, "_edge_timing_errs"}, 64'(snap_terr), 64'd0);
      chk({tag, "_resp_latency"}, 64'(snap_resp_cyc - (acc - 1)), 64'(RESP_LAT));
      chk({tag, "_ready_at_resp"}, {63'd0, snap_ready}, 64'd1);
      chk({tag, "_cs_high_at_resp"}, {63'd0, snap_cs}, 64'd1);
      chk({tag, "_resp_rdata"}, {32'd0, resp_rdata}, {32'd0, exp_rdata});
   endtask

   task automatic run_req(input string tag, input logic rw, input logic [1:0] w, input logic [5:0] a,
                          input logic [31:0] wd, input logic [31:0] tw,
                          input logic [31:0] exp_cmd, input logic [31:0] exp_rdata);
      int acc, r0;
      tgt_word = tw;
      r0 = resp_cnt;
      @(negedge clk); #1;
      drive(rw, w, a, wd);
      accept(acc);
      req_valid = 1'b0;
      wait_resp(r0);
      check_frame(tag, rw, wd, exp_cmd, exp_rdata, acc);
   endtask

   // command word from field rules by plain arithmetic
   function automatic logic [31:0] model_cmd(input logic rw, input logic [1:0] w, input logic [5:0] a);
      return (rw ? 32'h8000_0000 : 32'd0) + (32'(w) * 32'h2000_0000) + 32'(a);
   endfunction

   initial begin
      int acc1, acc2, r0, f0, r1cyc, n;
      logic        rw;
      logic [1:0]  w;
      logic [5:0]  a;
      logic [31:0] wd, tw, er;

      tbl[0] = '{rw:1'b1, w:2'b10, a:6'd5,    wd:32'hDEAD_BEEF, tw:32'h0BAD_F00D, exp_cmd:32'hC000_0005, exp_rdata:32'h0000_0000};
      tbl[1] = '{rw:1'b0, w:2'b11, a:6'h2A,   wd:32'h5555_5555, tw:32'h1234_5678, exp_cmd:32'h6000_002A, exp_rdata:32'h1234_5678};
      tbl[2] = '{rw:1'b1, w:2'b00, a:6'h3F,   wd:32'h0000_0001, tw:32'hAAAA_AAAA, exp_cmd:32'h8000_003F, exp_rdata:32'h1234_5678};
      tbl[3] = '{rw:1'b0, w:2'b01, a:6'h00,   wd:32'hFFFF_0000, tw:32'hFFFF_FFFF, exp_cmd:32'h2000_0000, exp_rdata:32'hFFFF_FFFF};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
      chk("rst_spi_clk", {63'd0, spi_clk}, 64'd0);
      chk("rst_spi_cs_n", {63'd0, spi_cs_n}, 64'd1);
      chk("rst_spi_mosi", {63'd0, spi_mosi}, 64'd0);
      rstb = 1'b1;

      // table vectors
      for (int i = 0; i < 4; i++)
         run_req($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].tw,
                 tbl[i].exp_cmd, tbl[i].exp_rdata);
      model_rdata = tbl[3].exp_rdata;

      // random transactions against the model
      for (int i = 0; i < 10; i++) begin
         rw = 1'($urandom); w = 2'($urandom); a = 6'($urandom);
         wd = $urandom; tw = $urandom;
         er = rw ? model_rdata : tw;
         run_req($sformatf("rnd%0d", i), rw, w, a, wd, tw, model_cmd(rw, w, a), er);
         model_rdata = er;
      end

      // read then write back-to-back with req_valid held
      tgt_word = 32'hCAFE_1234;
      r0 = resp_cnt;
      @(negedge clk); #1;
      drive(1'b0, 2'b01, 6'h11, 32'h0);
      accept(acc1);
      drive(1'b1, 2'b10, 6'h22, 32'h0F0F_1234);
      wait_resp(r0);
      r1cyc = snap_resp_cyc;
      check_frame("b2b_rd", 1'b0, 32'h0, model_cmd(1'b0, 2'b01, 6'h11), 32'hCAFE_1234, acc1);
      @(posedge clk); #1;
      acc2 = cyc;
      req_valid = 1'b0;
      wait_resp(r0 + 1);
      chk("b2b_cs_fall_after_resp", 64'(cs_fall_cyc - r1cyc), 64'd1);
      check_frame("b2b_wr", 1'b1, 32'h0F0F_1234, model_cmd(1'b1, 2'b10, 6'h22), 32'hCAFE_1234, acc2);
      model_rdata = 32'hCAFE_1234;

      // req_valid pulsed while busy is ignored
      f0 = frames; r0 = resp_cnt;
      @(negedge clk); #1;
      drive(1'b1, 2'b11, 6'h07, 32'h1357_9BDF);
      accept(acc1);
      req_valid = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      drive(1'b1, 2'b00, 6'h3C, 32'hFFFF_FFFF);
      @(negedge clk); #1;
      req_valid = 1'b0;
      wait_resp(r0);
      check_frame("busy", 1'b1, 32'h1357_9BDF, model_cmd(1'b1, 2'b11, 6'h07), model_rdata, acc1);
      repeat (600) @(negedge clk);
      chk("busy_frames", 64'(frames - f0), 64'd1);
      chk("busy_resps", 64'(resp_cnt - r0), 64'd1);

      // reset asserted 200 cycles into a read frame
      tgt_word = 32'h7777_0001;
      r0 = resp_cnt;
      @(negedge clk); #1;
      drive(1'b0, 2'b10, 6'h15, 32'h0);
      accept(acc1);
      req_valid = 1'b0;
      @(negedge clk); #1;
      n = 0;
      while (cyc - cs_fall_cyc < 200 && n < 1000) begin @(negedge clk); #1; n++; end
      chk("mid_rst_reached", 64'(cyc - cs_fall_cyc), 64'd200);
      rstb = 1'b0;
      #1;
      chk("mid_rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
      chk("mid_rst_spi_clk", {63'd0, spi_clk}, 64'd0);
      chk("mid_rst_mosi", {63'd0, spi_mosi}, 64'd0);
      chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
      chk("mid_rst_rdata", {32'd0, resp_rdata}, 64'd0);
      repeat (3) @(negedge clk);
      #1;
      rstb = 1'b1;
      model_rdata = 32'd0;
      repeat (600) @(negedge clk);
      chk("mid_rst_no_resp", 64'(resp_cnt), 64'(r0));
      run_req("post_rst_wr", 1'b1, 2'b01, 6'h2B, 32'hA5A5_5A5A, 32'h0,
              model_cmd(1'b1, 2'b01, 6'h2B), 32'd0);
      run_req("post_rst_rd", 1'b0, 2'b00, 6'h01, 32'h0, 32'h89AB_CDEF,
              model_cmd(1'b0, 2'b00, 6'h01), 32'h89AB_CDEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI mode-0 controller that issues single register transactions to the SPI register target in the test harness. It accepts one request at a time over a valid/ready port and serialises a command word followed by a data word, MSB first. On writes it drives the data word on MOSI; on reads it captures the returned word from MISO. It sits between the cocotb/firmware-side driver and the `spi_reg` target, driving `spi_clk`, `spi_cs_n` and `spi_mosi` from the system clock.

## Interface
Parameters:
- `ADDR_W`, 6: register address width; must satisfy ADDR_W ≤ REG_W-3.
- `REG_W`, 32: command-word and data-word width (bits per phase).
- `HALF_PERIOD`, 4: `spi_clk` half period in `clk` cycles; minimum 4.

Ports:
- `clk` input 1: system clock. One clock domain.
- `rstb` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle and accepting a request.
- `req_rw` input 1: 1 = write, 0 = read.
- `req_width` input 2: transaction width code, forwarded in the command word.
- `req_addr` input ADDR_W: register address.
- `req_wdata` input REG_W: write data, ignored on reads.
- `resp_valid` output 1: one-cycle pulse when the frame has completed.
- `resp_rdata` output REG_W: last read word; held until the next read completes.
- `spi_clk` output 1: serial clock, idles low.
- `spi_cs_n` output 1: chip select, active-low.
- `spi_mosi` output 1: controller data out.
- `spi_miso` input 1: target data in.

## Operation
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `spi_clk`=0, `spi_cs_n`=1, `spi_mosi`=0.
- Command word layout:
  - bit REG_W-1 = `req_rw`.
  - bits [REG_W-2:REG_W-3] = `req_width`.
  - bits [ADDR_W-1:0] = `req_addr`.
  - All other bits are 0.
- A handshake occurs when `req_valid` and `req_ready` are both high. The controller then latches every request field and shifts out `{cmd, req_rw ? req_wdata : 0}`, which is 2·REG_W bits.
- FSM states:
  - IDLE: `req_ready`=1. Moves to SETUP on a handshake.
  - SETUP: `spi_cs_n` low, MOSI carries the MSB. Lasts HALF_PERIOD cycles, then moves to SHIFT.
  - SHIFT: `spi_clk` toggles every HALF_PERIOD cycles. MOSI changes on each falling edge. MISO is sampled on each rising edge during bits REG_W..2·REG_W-1 of a read. After the 2·REG_W-th falling edge, moves to HOLD.
  - HOLD: `spi_clk` low, CS low, for HALF_PERIOD cycles. Then `spi_cs_n` goes high and the state moves to GAP.
  - GAP: CS high for HALF_PERIOD cycles. Then moves to IDLE with a `resp_valid` pulse.
- Read data is shifted in MSB first. `resp_rdata` updates only in the `resp_valid` cycle, and only for reads.
- `spi_mosi` is 0 during the read data phase and whenever CS is high.
- The half-period timer counts 0..HALF_PERIOD-1. The bit counter counts 0..2·REG_W-1; its width is $clog2(2·REG_W).
- Reset asserted mid-frame: all outputs return to their reset values immediately and the partial frame is discarded. No `resp_valid` is issued.
- `req_valid` while busy is ignored. The request must be held until it is accepted.

## Timing
- Handshake at cycle t:
  - `spi_cs_n` falls at t+1.
  - Rising edge k (k = 0..2·REG_W-1) occurs at t+1+(2k+1)·HALF_PERIOD.
  - The last falling edge occurs at t+1+4·REG_W·HALF_PERIOD.
  - `spi_cs_n` rises HALF_PERIOD cycles after the last falling edge.
  - `resp_valid` and `req_ready` are both high at t+1+(4·REG_W+2)·HALF_PERIOD. A new request can be accepted in that same cycle.
- MISO is sampled in the same cycle that `spi_clk` is driven high.
- With HALF_PERIOD ≥ 4, the target has at least 2·HALF_PERIOD cycles after the command-phase rising edge to present the read MSB.

## Configuration
- `SPI_REG_MASTER_MISO_SYNC_EN`:
  - Defined: `spi_miso` passes through a 2-flop synchroniser, and sampling is delayed to 2 cycles after each rising edge. This is still before the next falling edge.
  - Undefined: MISO is sampled directly and there is no added latency.
- Frame timing on the SPI pins is identical in both builds.

## Structure
- Shared package `spi_reg_pkg` holds:
  - The FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - Command-word field constants: RW bit position and width-field position.
- One sub-module, `spi_half_period_timer`: a down-counter that emits a one-cycle tick every HALF_PERIOD cycles. It is cleared on entry to each state.

## Test plan
All scenarios use REG_W=32, ADDR_W=6, HALF_PERIOD=4, with the controller looped to the `spi_reg` target.
- Write: addr 5, width 2'b10, data 0xDEADBEEF -> command word 0xC0000005 on MOSI. Target `reg_data_o`=0xDEADBEEF with `reg_data_o_dv` pulse. `resp_valid` at t+521.
- Read: addr 0x2A, target `reg_data_i`=0x12345678 -> command word 0x6000002A. `resp_rdata`=0x12345678 at `resp_valid`.
- Read then write issued back-to-back with `req_valid` held -> second CS fall occurs exactly 1 cycle after the first `resp_valid`. `resp_rdata` is unchanged by the write.
- `req_valid` pulsed while busy -> ignored. Exactly one frame is issued, with 64 `spi_clk` rising edges.
- `rstb` low at cycle 200 of a frame -> `spi_cs_n`=1 and `spi_clk`=0 immediately, no `resp_valid`. The next request completes correctly.
- MISO toggling between samples, in both macro builds -> captured word matches the level present at each sample point.
